// File: rtl/fft_pkg.sv
// Shared constants, complex-sample type and index helper for the parallel FFT.
package fft_pkg;

  localparam int DefaultWidth  = 16;
  localparam int DefaultNpoint = 3;
  localparam int DefaultWfrac  = 10;

  typedef struct packed {
    logic signed [DefaultWidth-1:0] re;
    logic signed [DefaultWidth-1:0] im;
  } cplx_t;

  function automatic int bit_rev(input int v, input int bits);
    int r;
    r = 0;
    for (int b = 0; b < bits; b++) begin
      r = r | (((v >> b) & 1) << (bits - 1 - b));
    end
    return r;
  endfunction

endpackage

// File: rtl/butterfly_unit.sv
// Combinational radix-2 DIT butterfly: t = (W*b) >>> WFRAC, a' = a + t, b' = a - t, wrapping.
module butterfly_unit
  import fft_pkg::*;
#(
  parameter int WIDTH = DefaultWidth,
  parameter int WFRAC = DefaultWfrac
) (
  input  logic signed [WIDTH-1:0] a_re_i,
  input  logic signed [WIDTH-1:0] a_im_i,
  input  logic signed [WIDTH-1:0] b_re_i,
  input  logic signed [WIDTH-1:0] b_im_i,
  input  logic signed [WIDTH-1:0] w_re_i,
  input  logic signed [WIDTH-1:0] w_im_i,
  output logic signed [WIDTH-1:0] a_re_o,
  output logic signed [WIDTH-1:0] a_im_o,
  output logic signed [WIDTH-1:0] b_re_o,
  output logic signed [WIDTH-1:0] b_im_o
);

  localparam int PW = 2 * WIDTH + 2;

  logic signed [PW-1:0] p_re, p_im, t_re, t_im, ar, ai;

  // Full-precision complex product before the fractional shift.
  assign p_re = PW'(w_re_i) * PW'(b_re_i) - PW'(w_im_i) * PW'(b_im_i);
  assign p_im = PW'(w_re_i) * PW'(b_im_i) + PW'(w_im_i) * PW'(b_re_i);
  assign t_re = p_re >>> WFRAC;
  assign t_im = p_im >>> WFRAC;
  assign ar   = PW'(a_re_i);
  assign ai   = PW'(a_im_i);

  assign a_re_o = WIDTH'(ar + t_re);
  assign a_im_o = WIDTH'(ai + t_im);
  assign b_re_o = WIDTH'(ar - t_re);
  assign b_im_o = WIDTH'(ai - t_im);

endmodule

// File: rtl/full_parallel_fft.sv
// Fully parallel pipelined radix-2 DIT FFT with loadable twiddles and output back-pressure.
module full_parallel_fft
  import fft_pkg::*;
#(
  parameter int WIDTH  = DefaultWidth,
  parameter int NPOINT = DefaultNpoint,
  parameter int WFRAC  = DefaultWfrac
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           din_valid,
  output logic                           din_busy,
  input  logic [WIDTH*(2**NPOINT)-1:0]   din_real,
  input  logic [WIDTH*(2**NPOINT)-1:0]   din_imag,
  output logic                           dout_valil,
  input  logic                           dout_busy,
  output logic [WIDTH*(2**NPOINT)-1:0]   dout_real,
  output logic [WIDTH*(2**NPOINT)-1:0]   dout_imag,
  input  logic                           din_weight_valid,
  input  logic [WIDTH-1:0]               din_weight_real,
  input  logic [WIDTH-1:0]               din_weight_imag
);

  localparam int N  = 2 ** NPOINT;
  localparam int H  = N / 2;
  localparam int IW = (NPOINT > 1) ? NPOINT - 1 : 1;

  logic signed [WIDTH-1:0] w_re_q [H];
  logic signed [WIDTH-1:0] w_im_q [H];
  logic [IW-1:0]           idx_q;
  logic                    loaded_q;

  // Layer 0 holds the bit-reversed input; layer s+1 holds the output of stage s.
  logic signed [WIDTH-1:0] re_q [NPOINT+1][N];
  logic signed [WIDTH-1:0] im_q [NPOINT+1][N];
  logic [NPOINT:0]         v_q;

  logic signed [WIDTH-1:0] bf_re [NPOINT][N];
  logic signed [WIDTH-1:0] bf_im [NPOINT][N];

  logic stall;

  assign stall    = v_q[NPOINT] & dout_busy;
  assign din_busy = ~loaded_q | din_weight_valid | stall;

  for (genvar s = 0; s < NPOINT; s++) begin : g_stage
    for (genvar i = 0; i < H; i++) begin : g_bf
      localparam int Half = 2 ** s;
      localparam int Top  = (i / Half) * 2 * Half + (i % Half);
      localparam int Tw   = (i % Half) * (N / (2 * Half));
      butterfly_unit #(
        .WIDTH (WIDTH),
        .WFRAC (WFRAC)
      ) u_bf (
        .a_re_i (re_q[s][Top]),
        .a_im_i (im_q[s][Top]),
        .b_re_i (re_q[s][Top+Half]),
        .b_im_i (im_q[s][Top+Half]),
        .w_re_i (w_re_q[Tw]),
        .w_im_i (w_im_q[Tw]),
        .a_re_o (bf_re[s][Top]),
        .a_im_o (bf_im[s][Top]),
        .b_re_o (bf_re[s][Top+Half]),
        .b_im_o (bf_im[s][Top+Half])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      idx_q    <= '0;
      loaded_q <= 1'b0;
      v_q      <= '0;
      for (int h = 0; h < H; h++) begin
        w_re_q[h] <= '0;
        w_im_q[h] <= '0;
      end
      for (int l = 0; l <= NPOINT; l++) begin
        for (int i = 0; i < N; i++) begin
          re_q[l][i] <= '0;
          im_q[l][i] <= '0;
        end
      end
    end else begin
      // Twiddle writes proceed even while the pipeline is stalled.
      if (din_weight_valid) begin
        w_re_q[idx_q] <= din_weight_real;
        w_im_q[idx_q] <= din_weight_imag;
        if (idx_q == IW'(H - 1)) begin
          idx_q    <= '0;
          loaded_q <= 1'b1;
        end else begin
          idx_q <= idx_q + IW'(1);
        end
      end
      if (!stall) begin
        v_q <= {v_q[NPOINT-1:0], din_valid & ~din_busy};
        for (int i = 0; i < N; i++) begin
          re_q[0][i] <= din_real[bit_rev(i, NPOINT)*WIDTH +: WIDTH];
          im_q[0][i] <= din_imag[bit_rev(i, NPOINT)*WIDTH +: WIDTH];
        end
        for (int s = 0; s < NPOINT; s++) begin
          for (int i = 0; i < N; i++) begin
            re_q[s+1][i] <= bf_re[s][i];
            im_q[s+1][i] <= bf_im[s][i];
          end
        end
      end
    end
  end

  assign dout_valil = v_q[NPOINT];

  for (genvar k = 0; k < N; k++) begin : g_out
    assign dout_real[k*WIDTH +: WIDTH] = re_q[NPOINT][k];
    assign dout_imag[k*WIDTH +: WIDTH] = im_q[NPOINT][k];
  end

endmodule

// File: tb/tb_full_parallel_fft.sv
// Directed + randomized bench for full_parallel_fft against an iterative FFT reference model.
module tb_full_parallel_fft;

  localparam int WIDTH  = 16;
  localparam int NPOINT = 3;
  localparam int WFRAC  = 10;
  localparam int N      = 8;
  localparam int H      = 4;
  localparam int FW     = WIDTH * N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          din_valid = 1'b0;
  logic          din_busy;
  logic [FW-1:0] din_real = '0;
  logic [FW-1:0] din_imag = '0;
  logic          dout_valil;
  logic          dout_busy = 1'b0;
  logic [FW-1:0] dout_real;
  logic [FW-1:0] dout_imag;
  logic          din_weight_valid = 1'b0;
  logic [WIDTH-1:0] din_weight_real = '0;
  logic [WIDTH-1:0] din_weight_imag = '0;

  int tests = 0;
  int fails = 0;
  int tw_re [H];
  int tw_im [H];
  int std_re [H] = '{1024, 724, 0, -724};
  int std_im [H] = '{0, -724, -1024, -724};

  always #5 clk = ~clk;

  full_parallel_fft #(
    .WIDTH  (WIDTH),
    .NPOINT (NPOINT),
    .WFRAC  (WFRAC)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .din_valid        (din_valid),
    .din_busy         (din_busy),
    .din_real         (din_real),
    .din_imag         (din_imag),
    .dout_valil       (dout_valil),
    .dout_busy        (dout_busy),
    .dout_real        (dout_real),
    .dout_imag        (dout_imag),
    .din_weight_valid (din_weight_valid),
    .din_weight_real  (din_weight_real),
    .din_weight_imag  (din_weight_imag)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int wrapw(input longint v);
    logic signed [WIDTH-1:0] t;
    t = v[WIDTH-1:0];
    return int'(t);
  endfunction

  function automatic int rev(input int v);
    int r;
    r = 0;
    for (int b = 0; b < NPOINT; b++) r = r | (((v >> b) & 1) << (NPOINT - 1 - b));
    return r;
  endfunction

  function automatic logic [FW-1:0] pack(input int a [N]);
    logic [FW-1:0] p;
    p = '0;
    for (int k = 0; k < N; k++) p[k*WIDTH +: WIDTH] = WIDTH'(a[k]);
    return p;
  endfunction

  // Textbook iterative Cooley-Tukey with truncated fixed-point twiddle products.
  task automatic model(input int xr [N], input int xi [N],
                       output logic [FW-1:0] er, output logic [FW-1:0] ei);
    int ar [N];
    int ai [N];
    for (int i = 0; i < N; i++) begin
      ar[i] = xr[rev(i)];
      ai[i] = xi[rev(i)];
    end
    for (int len = 2; len <= N; len = len * 2) begin
      for (int i = 0; i < N; i = i + len) begin
        for (int j = 0; j < len / 2; j++) begin
          int k, lo, hi;
          longint pr, pim, tr, ti, ur, ui;
          k   = j * (N / len);
          lo  = i + j;
          hi  = i + j + len / 2;
          pr  = longint'(tw_re[k]) * ar[hi] - longint'(tw_im[k]) * ai[hi];
          pim = longint'(tw_re[k]) * ai[hi] + longint'(tw_im[k]) * ar[hi];
          tr  = pr >>> WFRAC;
          ti  = pim >>> WFRAC;
          ur  = longint'(ar[lo]);
          ui  = longint'(ai[lo]);
          ar[lo] = wrapw(ur + tr);
          ai[lo] = wrapw(ui + ti);
          ar[hi] = wrapw(ur - tr);
          ai[hi] = wrapw(ui - ti);
        end
      end
    end
    er = pack(ar);
    ei = pack(ai);
  endtask

  task automatic load_weights(input int wr [H], input int wi [H]);
    for (int h = 0; h < H; h++) begin
      din_weight_valid = 1'b1;
      din_weight_real  = WIDTH'(wr[h]);
      din_weight_imag  = WIDTH'(wi[h]);
      #1;
      chk("busy_during_load", FW'(din_busy), FW'(1));
      step();
      tw_re[h] = wr[h];
      tw_im[h] = wi[h];
    end
    din_weight_valid = 1'b0;
    #1;
    chk("busy_after_load", FW'(din_busy), FW'(0));
  endtask

  // Leaves the result frame on the output; caller consumes it with step().
  task automatic send_and_check(input string tag, input int xr [N], input int xi [N]);
    logic [FW-1:0] er, ei;
    int cnt;
    model(xr, xi, er, ei);
    din_real  = pack(xr);
    din_imag  = pack(xi);
    din_valid = 1'b1;
    #1;
    chk({tag, "_ready"}, FW'(din_busy), FW'(0));
    step();
    din_valid = 1'b0;
    cnt = 0;
    while (!dout_valil && cnt < 20) begin
      step();
      cnt++;
    end
    chk({tag, "_latency"}, FW'(cnt), FW'(NPOINT));
    chk({tag, "_real"}, dout_real, er);
    chk({tag, "_imag"}, dout_imag, ei);
  endtask

  task automatic rand_frame(output int xr [N], output int xi [N]);
    for (int i = 0; i < N; i++) begin
      xr[i] = int'($urandom_range(4000)) - 2000;
      xi[i] = int'($urandom_range(4000)) - 2000;
    end
  endtask

  initial begin
    int xr [N];
    int xi [N];
    int fr [4][N];
    int fi [4][N];
    int rw_re [H];
    int rw_im [H];
    logic [FW-1:0] q_re [4];
    logic [FW-1:0] q_im [4];
    int seen;

    // Reset state
    step();
    step();
    rst_n = 1'b0;
    chk("rst_valid", FW'(dout_valil), FW'(0));
    chk("rst_busy", FW'(din_busy), FW'(1));
    chk("rst_dout_real", dout_real, '0);
    chk("rst_dout_imag", dout_imag, '0);

    load_weights(std_re, std_im);

    for (int i = 0; i < N; i++) begin
      xr[i] = 0;
      xi[i] = 0;
    end
    send_and_check("zero", xr, xi);
    chk("zero_bins_real", dout_real, '0);
    chk("zero_bins_imag", dout_imag, '0);
    step();

    xr[0] = 100;
    send_and_check("impulse", xr, xi);
    chk("impulse_bins_real", dout_real, {N{16'd100}});
    chk("impulse_bins_imag", dout_imag, '0);
    step();

    for (int i = 0; i < N; i++) xr[i] = 10;
    send_and_check("const", xr, xi);
    chk("const_bins_real", dout_real, FW'(80));
    chk("const_bins_imag", dout_imag, '0);
    step();

    for (int f = 0; f < 4; f++) begin
      rand_frame(xr, xi);
      send_and_check("rand", xr, xi);
      step();
    end

    // Back-to-back frames, then a 5-cycle stall on the first output
    for (int f = 0; f < 4; f++) begin
      rand_frame(fr[f], fi[f]);
      model(fr[f], fi[f], q_re[f], q_im[f]);
    end
    for (int f = 0; f < 4; f++) begin
      din_real  = pack(fr[f]);
      din_imag  = pack(fi[f]);
      din_valid = 1'b1;
      #1;
      chk("b2b_ready", FW'(din_busy), FW'(0));
      step();
    end
    rand_frame(xr, xi);
    din_real  = pack(xr);
    din_imag  = pack(xi);
    dout_busy = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      chk("stall_valid", FW'(dout_valil), FW'(1));
      chk("stall_real", dout_real, q_re[0]);
      chk("stall_imag", dout_imag, q_im[0]);
      chk("stall_busy", FW'(din_busy), FW'(1));
      step();
    end
    dout_busy = 1'b0;
    din_valid = 1'b0;
    #1;
    for (int f = 0; f < 4; f++) begin
      chk("drain_valid", FW'(dout_valil), FW'(1));
      chk("drain_real", dout_real, q_re[f]);
      chk("drain_imag", dout_imag, q_im[f]);
      step();
    end
    seen = 0;
    for (int c = 0; c < NPOINT + 2; c++) begin
      if (dout_valil) seen++;
      step();
    end
    chk("drain_no_extra", FW'(seen), FW'(0));

    // Random twiddle set
    for (int h = 0; h < H; h++) begin
      rw_re[h] = int'($urandom_range(2048)) - 1024;
      rw_im[h] = int'($urandom_range(2048)) - 1024;
    end
    load_weights(rw_re, rw_im);
    for (int f = 0; f < 2; f++) begin
      rand_frame(xr, xi);
      send_and_check("rand_tw", xr, xi);
      step();
    end

    // Reset while a frame is in flight
    rand_frame(xr, xi);
    din_real  = pack(xr);
    din_imag  = pack(xi);
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    chk("midrst_valid", FW'(dout_valil), FW'(0));
    chk("midrst_busy", FW'(din_busy), FW'(1));
    seen = 0;
    for (int c = 0; c < NPOINT + 2; c++) begin
      if (dout_valil) seen++;
      step();
    end
    chk("midrst_discarded", FW'(seen), FW'(0));
    chk("midrst_busy_hold", FW'(din_busy), FW'(1));
    load_weights(std_re, std_im);
    rand_frame(xr, xi);
    send_and_check("post_rst", xr, xi);
    step();

    // A lone overwrite of W[0] must not clear the loaded flag
    din_weight_valid = 1'b1;
    din_weight_real  = WIDTH'(std_re[0]);
    din_weight_imag  = WIDTH'(std_im[0]);
    step();
    din_weight_valid = 1'b0;
    #1;
    chk("overwrite_keeps_loaded", FW'(din_busy), FW'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/full_parallel_fft.md
FULL_PARALLEL_FFT -- requirements
Module: full_parallel_fft

Interface
REQ-001 SHALL have parameter WIDTH, default 16: bit width of each signed real/imag sample and of each twiddle component.
REQ-002 SHALL have parameter NPOINT, default 3: log2 of FFT size, so N = 2**NPOINT.
REQ-003 SHALL have parameter WFRAC, default 10: fractional bits of twiddle values (1.0 = 1024).
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, synchronous and active-high (asserted = 1).
REQ-006 din_valid  in  1  input frame valid.
REQ-007 din_busy  out  1  block cannot accept a frame this cycle.
REQ-008 din_real, din_imag  in  WIDTH*N each  input frame; sample i at bits [i*WIDTH +: WIDTH], natural order, two's complement.
REQ-009 dout_valil  out  1  output frame valid (port name fixed as spelled).
REQ-010 dout_busy  in  1  downstream back-pressure.
REQ-011 dout_real, dout_imag  out  WIDTH*N each  output bins; bin k at bits [k*WIDTH +: WIDTH], natural order.
REQ-012 din_weight_valid  in  1  twiddle write strobe.
REQ-013 din_weight_real, din_weight_imag  in  WIDTH each  twiddle value, signed, WFRAC fractional bits.

Function
REQ-014 Twiddle load: each cycle with din_weight_valid=1 SHALL write W[idx] and increment idx; N/2 writes fill W[0..N/2-1], W[k] = exp(-j*2*pi*k/N).
REQ-015 After the N/2-th write, idx SHALL wrap to 0 and a weights_loaded flag SHALL set; later writes overwrite from W[0] and do not clear the flag.
REQ-016 A frame SHALL be accepted when din_valid=1 and din_busy=0 in the same cycle.
REQ-017 din_busy SHALL be 1 while weights_loaded=0, while din_weight_valid=1, or while the pipeline is stalled (REQ-021).
REQ-018 Computation: radix-2 DIT, input bit-reversal by wiring, NPOINT stages of N/2 butterflies each, all butterflies of a stage in parallel.
REQ-019 Butterfly: t = W*b, with the full complex product arithmetic-shifted right by WFRAC (truncation); a' = a + t, b' = a - t; results truncated to WIDTH bits (wrap on overflow); no per-stage scaling.
REQ-020 Each stage SHALL be registered with its own valid bit; latency from accepting edge to dout_valil=1 is exactly NPOINT cycles; throughput one frame per cycle.
REQ-021 Stall: when dout_valil=1 and dout_busy=1, all stage registers and valids SHALL hold; the output frame stays stable until dout_busy=0.
REQ-022 dout_valil=1 with dout_busy=0 SHALL consume the frame at that edge.
REQ-023 Twiddle writes during frame processing SHALL take effect immediately; correctness of in-flight frames is then not required.

Reset
REQ-024 On rst_n=1 at a rising edge: all stage valids, dout_valil, idx, weights_loaded SHALL clear to 0; W[] and data registers SHALL clear to 0; dout_real/dout_imag read 0.
REQ-025 Immediately after reset din_busy SHALL be 1 (weights not loaded); in-flight frames SHALL be discarded.

Structure
REQ-026 A shared package fft_pkg SHALL hold the default WIDTH/NPOINT/WFRAC constants and a complex-sample typedef (real, imag).
REQ-027 One sub-module butterfly_unit (combinational complex butterfly per REQ-019) SHALL be instantiated NPOINT*N/2 times; stage registers live in full_parallel_fft.

Verification
REQ-028 Reset, load 4 standard twiddles (N=8, WFRAC=10: (1024,0),(724,-724),(0,-1024),(-724,-724)) -> din_busy 1 during load, 0 afterwards.
REQ-029 All-zero frame -> after 3 cycles dout_valil=1, all 8 bins real=0, imag=0.
REQ-030 Impulse x[0]=100, rest 0 -> all bins real=100, imag=0.
REQ-031 Constant x[i]=10 -> bin0 real=80, all other bins 0 (real and imag).
REQ-032 Back-to-back frames with dout_busy held 1 for 5 cycles -> output frame held stable, din_busy=1 while stalled, no frame lost or duplicated after release.
REQ-033 Reset asserted mid-stream -> dout_valil=0 next cycle, din_busy=1 until twiddles reloaded.
